regfile_io: RTL and testbench

- Register file feeding the register operand of the MULTI unit and the other ALU ops; stores the MULTI/ALU result on writeback.
- Eight 8-bit registers (`REG_SIZE`), two combinational read ports, one synchronous write port.
- Register IN_REG is memory-mapped to a switch-input latch filled by a press/release handshake. Register OUT_REG drives the LED output.
- Raises a stall to the core while an input instruction waits for the user.

---
 rtl/regfile_io.sv | 122 ++++++++++++
 tb/tb_regfile_io.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_io.sv
// rtl/regfile_io.sv - eight-entry 8-bit register file with switch-input latch and LED output register
// Two combinational read ports, one gated write port, and a press/release handshake that stalls the core.
module regfile_io #(
  parameter int IN_REG      = 1,
  parameter int OUT_REG     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ra1,
  input  logic [2:0] ra2,
  output logic [7:0] rd1,
  output logic [7:0] rd2,
  input  logic       we,
  input  logic [2:0] wa,
  input  logic [7:0] wd,
  input  logic       in_req,
  input  logic [7:0] sw_data,
  input  logic       sw_ready,
  output logic       stall,
  output logic [7:0] out_data
);

  localparam logic [2:0] IN_ADDR  = 3'(IN_REG);
  localparam logic [2:0] OUT_ADDR = 3'(OUT_REG);

  typedef enum logic [1:0] {
    ARMED        = 2'd0,
    DONE         = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  logic [7:0]             regs_q [8];
  logic [7:0]             latch_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   rdy_prev_q;
  state_t                 state_q;

  logic rdy_s;
  logic rise;
  logic wr_en;

  assign rdy_s = sync_q[SYNC_STAGES-1];
  assign rise  = rdy_s && !rdy_prev_q;
  assign stall = !reset && in_req && (state_q != DONE);
  assign wr_en = we && !stall && (wa != 3'd0) && (wa != IN_ADDR);

  assign out_data = regs_q[OUT_ADDR];

  always_comb begin
    rd1 = regs_q[ra1];
    if (ra1 == 3'd0) begin
      rd1 = 8'h00;
    end else if (ra1 == IN_ADDR) begin
      rd1 = latch_q;
    end
  end

  always_comb begin
    rd2 = regs_q[ra2];
    if (ra2 == 3'd0) begin
      rd2 = 8'h00;
    end else if (ra2 == IN_ADDR) begin
      rd2 = latch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      regs_q[wa] <= wd;
    end
  end

  // Until the chain has refilled after reset, rdy_prev is held high so a button
  // still held through reset reads as already pressed rather than as a new rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      fill_q     <= '0;
      rdy_prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_ready};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      if (fill_q[SYNC_STAGES-1]) begin
        rdy_prev_q <= rdy_s;
      end else begin
        rdy_prev_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARMED;
      latch_q <= 8'h00;
    end else begin
      case (state_q)
        ARMED: begin
          if (in_req && rise) begin
            latch_q <= sw_data;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= rdy_s ? WAIT_RELEASE : ARMED;
        end
        WAIT_RELEASE: begin
          if (!rdy_s) begin
            state_q <= ARMED;
          end
        end
        default: state_q <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_io.sv
// tb/tb_regfile_io.sv - scoreboard bench for regfile_io
// Stimulus queues expected values per cycle; a negedge monitor pops and compares them.
module tb_regfile_io;

  localparam int SEL_RD1   = 0;
  localparam int SEL_RD2   = 1;
  localparam int SEL_OUT   = 2;
  localparam int SEL_STALL = 3;

  typedef struct {
    int         sel;
    logic [7:0] val;
    string      tag;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [2:0] ra1, ra2, wa;
  logic [7:0] rd1, rd2, wd, sw_data, out_data;
  logic       we, in_req, sw_ready, stall;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  bit   stim_done;

  regfile_io dut (
    .clk      (clk),
    .reset    (reset),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .in_req   (in_req),
    .sw_data  (sw_data),
    .sw_ready (sw_ready),
    .stall    (stall),
    .out_data (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int sel, input logic [7:0] val, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: every expectation queued during a cycle is judged at that cycle's negedge.
  initial begin
    exp_t       e;
    logic [7:0] act;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.sel)
          SEL_RD1:   act = rd1;
          SEL_RD2:   act = rd2;
          SEL_OUT:   act = out_data;
          default:   act = {7'd0, stall};
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %02h expected %02h at %0t", e.tag, act, e.val, $time);
        end
      end
    end
  end

  initial begin
    stim_done = 1'b0;
    reset = 1'b1; in_req = 1'b1; we = 1'b0; wa = 3'd0; wd = 8'h00;
    ra1 = 3'd0; ra2 = 3'd0; sw_data = 8'h00; sw_ready = 1'b0;
    step();
    step();
    expect_val(SEL_STALL, 8'h00, "reset_stall_forced_low");
    expect_val(SEL_OUT,   8'h00, "reset_out_data");
    step();

    // Test 1: write r3, visible only after the edge
    reset = 1'b0; in_req = 1'b0;
    we = 1'b1; wa = 3'd3; wd = 8'h06; ra1 = 3'd3;
    expect_val(SEL_RD1, 8'h00, "t1_no_bypass");
    expect_val(SEL_STALL, 8'h00, "t1_stall_idle");
    step();
    we = 1'b0;
    expect_val(SEL_RD1, 8'h06, "t1_r3_read");
    expect_val(SEL_OUT, 8'h00, "t1_out_zero");

    // Test 2: OUT_REG mirror, r0 and IN_REG write protection
    we = 1'b1; wa = 3'd2; wd = 8'h04;
    expect_val(SEL_OUT, 8'h00, "t2_out_before_edge");
    step();
    wa = 3'd0; wd = 8'hFF;
    expect_val(SEL_OUT, 8'h04, "t2_out_updated");
    step();
    wa = 3'd1; wd = 8'hAA; ra1 = 3'd0;
    expect_val(SEL_RD1, 8'h00, "t2_r0_zero");
    step();
    we = 1'b0; ra1 = 3'd1; ra2 = 3'd2;
    expect_val(SEL_RD1, 8'h00, "t2_latch_unchanged");
    expect_val(SEL_RD2, 8'h04, "t2_rd2_r2");

    // Test 3: capture latency; cycle numbering starts at this stimulus point
    step();
    in_req = 1'b1; sw_data = 8'h55; sw_ready = 1'b0; ra1 = 3'd1;
    for (int c = 0; c <= 12; c++) begin
      if (c == 10) sw_ready = 1'b1;
      expect_val(SEL_STALL, 8'h01, $sformatf("t3_stall_hi_c%0d", c));
      if (c == 12) expect_val(SEL_RD1, 8'h00, "t3_latch_not_yet");
      step();
    end
    expect_val(SEL_STALL, 8'h00, "t3_stall_low_c13");
    expect_val(SEL_RD1, 8'h55, "t3_latch_55");
    step();

    // Test 4: button still held -> second input instruction waits for release + new press
    for (int c = 14; c <= 22; c++) begin
      if (c == 16) sw_ready = 1'b0;
      if (c == 18) sw_data = 8'h23;
      if (c == 20) sw_ready = 1'b1;
      expect_val(SEL_STALL, 8'h01, $sformatf("t4_stall_hi_c%0d", c));
      expect_val(SEL_RD1, 8'h55, $sformatf("t4_latch_old_c%0d", c));
      step();
    end
    expect_val(SEL_STALL, 8'h00, "t4_stall_low_c23");
    expect_val(SEL_RD1, 8'h23, "t4_latch_23");
    step();

    // Test 5: write dropped while stalled, accepted once stall clears
    we = 1'b1; wa = 3'd4; wd = 8'h11; ra2 = 3'd4;
    expect_val(SEL_STALL, 8'h01, "t5_stall_during_write");
    step();
    we = 1'b0; sw_ready = 1'b0;
    expect_val(SEL_RD2, 8'h00, "t5_r4_unchanged");
    for (int c = 26; c <= 31; c++) begin
      if (c == 29) begin
        sw_data = 8'h77;
        sw_ready = 1'b1;
      end
      step();
    end
    in_req = 1'b0; we = 1'b1; wa = 3'd4; wd = 8'h11;
    expect_val(SEL_RD1, 8'h77, "t5_latch_77");
    expect_val(SEL_STALL, 8'h00, "t5_no_stall");
    step();
    we = 1'b0; in_req = 1'b1;
    expect_val(SEL_RD2, 8'h11, "t5_r4_written");
    expect_val(SEL_STALL, 8'h01, "t5_wait_release_stall");
    step();
    in_req = 1'b0;
    expect_val(SEL_STALL, 8'h00, "t5_drop_in_req");
    step();

    // Test 6: reset while waiting for release with the button held
    in_req = 1'b1;
    reset = 1'b1;
    expect_val(SEL_STALL, 8'h00, "t6_stall_under_reset");
    step();
    ra1 = 3'd1; ra2 = 3'd3;
    expect_val(SEL_RD1, 8'h00, "t6_latch_cleared");
    expect_val(SEL_RD2, 8'h00, "t6_r3_cleared");
    expect_val(SEL_OUT, 8'h00, "t6_out_cleared");
    step();
    reset = 1'b0;
    for (int c = 37; c <= 53; c++) begin
      if (c == 47) sw_ready = 1'b0;
      if (c == 48) sw_data = 8'h9A;
      if (c == 51) sw_ready = 1'b1;
      if (c >= 38) begin
        expect_val(SEL_STALL, 8'h01, $sformatf("t6_stall_hi_c%0d", c));
        expect_val(SEL_RD1, 8'h00, $sformatf("t6_no_capture_c%0d", c));
      end
      step();
    end
    expect_val(SEL_STALL, 8'h00, "t6_stall_low_after_repress");
    expect_val(SEL_RD1, 8'h9A, "t6_latch_9a");
    step();
    in_req = 1'b0;
    step();
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

endmodule
